// File: rtl/tinyalu_arbiter.sv
// ============================================================================
//  Module   : tinyalu_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one TinyALU between two
//             requesters. Accepts a request, drives the ALU start/op/A/B
//             handshake until done (or a watchdog timeout), then returns the
//             result to the granted requester with backpressure. Illegal ops
//             are answered locally with an error response.
//  Ports    : clk, reset                  - clock, synchronous active-high reset
//             reqN_valid/ready/a/b/op     - request channel, N = 0,1
//             rspN_valid/ready/result/err - response channel, N = 0,1
//             alu_start/op/a/b            - ALU command, held until alu_done
//             alu_done/alu_result         - ALU completion and result
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tinyalu_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_W-1:0]     req0_a,
    input  logic [DATA_W-1:0]     req0_b,
    input  logic [2:0]            req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_W-1:0]     req1_a,
    input  logic [DATA_W-1:0]     req1_b,
    input  logic [2:0]            req1_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [2*DATA_W-1:0]   rsp0_result,
    output logic                  rsp0_err,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [2*DATA_W-1:0]   rsp1_result,
    output logic                  rsp1_err,
    output logic                  alu_start,
    output logic [2:0]            alu_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic                  alu_done,
    input  logic [2*DATA_W-1:0]   alu_result
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [2:0]            op_q, op_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  sel;
    logic [2:0]            sel_op;
    logic                  sel_legal;
    logic                  rsp_take;

    // Ready is only offered in IDLE. On a tie, the requester that did not
    // win last time gets the slot; a ready implies the matching valid.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant_q;
                req1_ready = !last_grant_q;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign accept    = req0_ready | req1_ready;
    assign sel       = req1_ready;
    assign sel_op    = sel ? req1_op : req0_op;
    assign sel_legal = (sel_op == 3'b001) || (sel_op == 3'b010) ||
                       (sel_op == 3'b011) || (sel_op == 3'b100);
    assign rsp_take  = grant_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    a_d          = sel ? req1_a : req0_a;
                    b_d          = sel ? req1_b : req0_b;
                    op_d         = sel_op;
                    cnt_d        = '0;
                    if (sel_legal) begin
                        state_d = S_BUSY;
                    end else begin
                        // Illegal op never reaches the ALU.
                        state_d  = S_RESP;
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                // A completion in the final watchdog cycle still counts as done.
                if (alu_done) begin
                    state_d  = S_RESP;
                    result_d = alu_result;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = S_RESP;
                    result_d = '0;
                    err_d    = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_take) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    assign alu_start   = (state_q == S_BUSY);
    assign alu_op      = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;

    assign rsp0_valid  = (state_q == S_RESP) && !grant_q;
    assign rsp1_valid  = (state_q == S_RESP) &&  grant_q;
    assign rsp0_result = rsp0_valid ? result_q : '0;
    assign rsp1_result = rsp1_valid ? result_q : '0;
    assign rsp0_err    = rsp0_valid & err_q;
    assign rsp1_err    = rsp1_valid & err_q;

endmodule

`default_nettype wire

// File: tb/tb_tinyalu_arbiter.sv
// ============================================================================
//  Module   : tb_tinyalu_arbiter
//  Purpose  : Self-checking bench for tinyalu_arbiter: directed scenarios
//             followed by randomized requests against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tinyalu_arbiter;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [1:0]                    req_valid;
    logic [1:0]                    req_ready;
    logic [1:0][DATA_W-1:0]        req_a;
    logic [1:0][DATA_W-1:0]        req_b;
    logic [1:0][2:0]               req_op;
    logic [1:0]                    rsp_valid;
    logic [1:0]                    rsp_ready;
    logic [1:0][2*DATA_W-1:0]      rsp_result;
    logic [1:0]                    rsp_err;
    logic                          alu_start;
    logic [2:0]                    alu_op;
    logic [DATA_W-1:0]             alu_a;
    logic [DATA_W-1:0]             alu_b;
    logic                          alu_done;
    logic [2*DATA_W-1:0]           alu_result;

    int n_cmp = 0;
    int n_mis = 0;
    int last_grant;

    always #5 clk = ~clk;

    tinyalu_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req_valid[0]),
        .req0_ready  (req_ready[0]),
        .req0_a      (req_a[0]),
        .req0_b      (req_b[0]),
        .req0_op     (req_op[0]),
        .req1_valid  (req_valid[1]),
        .req1_ready  (req_ready[1]),
        .req1_a      (req_a[1]),
        .req1_b      (req_b[1]),
        .req1_op     (req_op[1]),
        .rsp0_valid  (rsp_valid[0]),
        .rsp0_ready  (rsp_ready[0]),
        .rsp0_result (rsp_result[0]),
        .rsp0_err    (rsp_err[0]),
        .rsp1_valid  (rsp_valid[1]),
        .rsp1_ready  (rsp_ready[1]),
        .rsp1_result (rsp_result[1]),
        .rsp1_err    (rsp_err[1]),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_done    (alu_done),
        .alu_result  (alu_result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // What a TinyALU computes for a legal op.
    function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return 16'(a & b);
            3'd3:    return 16'(a ^ b);
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic set_req(input int who, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid[who] = 1'b1;
        req_op[who]    = op;
        req_a[who]     = a;
        req_b[who]     = b;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        rsp_ready  = '0;
        alu_done   = 1'b0;
        alu_result = '0;
        tick();
        tick();
        reset      = 1'b0;
        last_grant = 1;
    endtask

    // Starts in IDLE with requests already driven; 'who' must be the winner.
    // The ALU answers on BUSY cycle 'lat' (never if lat >= TIMEOUT); the
    // response is held 'hold' extra cycles before being taken.
    task automatic run_txn(input int who, input int lat, input int hold,
                           input logic chk_const, input logic [15:0] want);
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        legal;
        logic        exp_err;
        logic [15:0] exp_res;
        #1;
        op    = req_op[who];
        a     = req_a[who];
        b     = req_b[who];
        legal = (op >= 3'd1) && (op <= 3'd4);
        check("ready_winner", 32'(req_ready[who]), 32'd1);
        check("ready_loser", 32'(req_ready[1-who]), 32'd0);
        tick();
        last_grant     = who;
        req_valid[who] = 1'b0;
        if (legal) begin
            check("alu_op", 32'(alu_op), 32'(op));
            check("alu_a", 32'(alu_a), 32'(a));
            check("alu_b", 32'(alu_b), 32'(b));
            check("busy_no_rsp", 32'(rsp_valid), 32'd0);
            for (int k = 0; k < TIMEOUT; k++) begin
                check("alu_start_high", 32'(alu_start), 32'd1);
                if (k == lat) begin
                    alu_done   = 1'b1;
                    alu_result = alu_model(op, a, b);
                end
                tick();
                alu_done   = 1'b0;
                alu_result = 16'($urandom);
                if (k == lat) break;
            end
        end
        exp_err = !legal || (lat >= TIMEOUT);
        exp_res = exp_err ? 16'h0000 : alu_model(op, a, b);
        check("alu_start_low", 32'(alu_start), 32'd0);
        if (chk_const) check("spec_vector", 32'(rsp_result[who]), 32'(want));
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid_win", 32'(rsp_valid[who]), 32'd1);
            check("rsp_valid_other", 32'(rsp_valid[1-who]), 32'd0);
            check("rsp_result", 32'(rsp_result[who]), 32'(exp_res));
            check("rsp_err", 32'(rsp_err[who]), 32'(exp_err));
            check("ready_in_resp", 32'(req_ready), 32'd0);
            if (h == hold) rsp_ready[who] = 1'b1;
            tick();
        end
        rsp_ready[who] = 1'b0;
        check("rsp_cleared", 32'(rsp_valid), 32'd0);
        check("start_gap", 32'(alu_start), 32'd0);
    endtask

    initial begin
        int mask;
        int who;
        // Reset state
        do_reset();
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);

        // Single add
        set_req(0, 3'b001, 8'h12, 8'h34);
        run_txn(0, 3, 0, 1'b1, 16'h0046);

        // Tie after reset: req0 first, response held 5 cycles, then req1
        do_reset();
        set_req(0, 3'b100, 8'hFF, 8'hFF);
        set_req(1, 3'b011, 8'hAA, 8'h0F);
        run_txn(0, 1, 5, 1'b1, 16'hFE01);
        run_txn(1, 2, 0, 1'b1, 16'h00A5);
        // Next tie goes back to req0
        set_req(0, 3'b001, 8'hFF, 8'h01);
        set_req(1, 3'b010, 8'hF0, 8'h3C);
        run_txn(0, 0, 0, 1'b1, 16'h0100);
        run_txn(1, 0, 2, 1'b1, 16'h0030);

        // Illegal op
        set_req(1, 3'b101, 8'h55, 8'h66);
        run_txn(1, 0, 1, 1'b1, 16'h0000);

        // Hung ALU: watchdog
        set_req(0, 3'b001, 8'h01, 8'h02);
        run_txn(0, 1000, 0, 1'b1, 16'h0000);

        // Done coincides with the last watchdog cycle: done wins
        set_req(0, 3'b100, 8'h10, 8'h10);
        run_txn(0, TIMEOUT - 1, 0, 1'b1, 16'h0100);

        // Reset mid-BUSY, then a late alu_done
        set_req(0, 3'b001, 8'h33, 8'h44);
        #1;
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_start", 32'(alu_start), 32'd0);
        check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        reset      = 1'b0;
        last_grant = 1;
        alu_done   = 1'b1;
        alu_result = 16'h1234;
        tick();
        alu_done = 1'b0;
        check("late_done_rsp", 32'(rsp_valid), 32'd0);
        check("late_done_start", 32'(alu_start), 32'd0);
        set_req(0, 3'b010, 8'h0F, 8'h0F);
        run_txn(0, 2, 0, 1'b1, 16'h000F);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            mask = $urandom_range(1, 3);
            for (int r = 0; r < 2; r++) begin
                if (mask[r]) set_req(r, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            end
            if (mask == 3) who = 1 - last_grant;
            else           who = (mask == 2) ? 1 : 0;
            run_txn(who, $urandom_range(0, 16), $urandom_range(0, 3), 1'b0, 16'h0000);
            if (mask == 3) begin
                run_txn(1 - who, $urandom_range(0, 16), $urandom_range(0, 3), 1'b0, 16'h0000);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
